// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, sequencer states and helpers for alu_arbiter
//
// Purpose: single home for the ALU opcode values the arbiter needs to know
// about, the sequencer state encoding and the carry-consumer test.
// Ports: none (package).

package alu_pkg;

  // ALU opcodes the arbiter either drives itself or has to recognise.
  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ASRC = 4'b1011;
  localparam logic [3:0] OP_ASLC = 4'b1100;

  // Sequencer states; explicit values keep the encoding stable for debug.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_EXEC  = 3'd2,
    ST_FLAG  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Shifts through carry read the ALU's internal carry register, so the
  // owner's saved carry has to be loaded into it first.
  function automatic logic uses_carry(input logic [3:0] op);
    return (op == OP_ASRC) || (op == OP_ASLC);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with explicit advance strobe
//
// Purpose: picks one of two valid requesters; on contention the one not
// granted last wins. The history only moves when the user strobes advance,
// so a grant that is offered but not yet completed does not rotate priority.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req0, req1      request lines
//   advance         record owner as the most recent grant
//   owner           requester that completed service (sampled with advance)
//   gnt0, gnt1      one-hot (or zero) combinational grant

module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  input  logic owner,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  // Reset to 1 so requester 0 wins the very first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= owner;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (last_grant) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one 16-bit ALU between two requesters
//
// Purpose: accepts one operation at a time from two issuing units
// (round-robin), sequences it through the ALU (optional carry prime, execute,
// flag capture) and returns result plus flags to the issuing unit. Each
// requester keeps a private carry that is restored into the ALU before any
// carry-consuming shift.
// Ports:
//   clk, rst_n                              clock shared with ALU, async reset
//   reqN_valid/ready, reqN_a/b/op           request channel, N = 0,1
//   rspN_valid/ready, rspN_out              response channel, N = 0,1
//   rspN_carry/zero/bigger                  flags of the returned operation
//   alu_ina, alu_inb, alu_op                drive to the ALU
//   alu_out, alu_carry/zero/bigger          ALU result and registered flags

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_out,
  output logic              rsp0_carry,
  output logic              rsp0_zero,
  output logic              rsp0_bigger,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_out,
  output logic              rsp1_carry,
  output logic              rsp1_zero,
  output logic              rsp1_bigger,

  output logic [DATA_W-1:0] alu_ina,
  output logic [DATA_W-1:0] alu_inb,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_bigger
);

  state_t            state;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic              owner_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic              zero_q;
  logic              bigger_q;
  logic [1:0]        saved_carry;

  logic              gnt0;
  logic              gnt1;
  logic              handshake;
  logic              rsp_take;
  logic              advance;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [OP_W-1:0]   op_sel;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .advance (advance),
    .owner   (owner_q),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  // Ready is masked by rst_n so a requester holding valid through reset
  // never sees ready while the block is held in reset.
  assign req0_ready = rst_n && (state == ST_IDLE) && gnt0;
  assign req1_ready = rst_n && (state == ST_IDLE) && gnt1;
  assign handshake  = req0_ready || req1_ready;

  assign a_sel  = req1_ready ? req1_a  : req0_a;
  assign b_sel  = req1_ready ? req1_b  : req0_b;
  assign op_sel = req1_ready ? req1_op : req0_op;

  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;
  assign advance  = (state == ST_RESP) && rsp_take;

  assign rsp0_valid = (state == ST_RESP) && !owner_q;
  assign rsp1_valid = (state == ST_RESP) &&  owner_q;

  // Both response ports show the shared result registers; only the owner's
  // valid is raised, so the non-owner copy is never consumed.
  assign rsp0_out    = result_q;
  assign rsp0_carry  = carry_q;
  assign rsp0_zero   = zero_q;
  assign rsp0_bigger = bigger_q;
  assign rsp1_out    = result_q;
  assign rsp1_carry  = carry_q;
  assign rsp1_zero   = zero_q;
  assign rsp1_bigger = bigger_q;

  // ALU drive. PRIME computes 16'hFFFF + saved_carry: its carry-out equals
  // saved_carry, which the ALU registers and presents during EXEC.
  always_comb begin
    alu_ina = '0;
    alu_inb = '0;
    alu_op  = OP_PASS;
    case (state)
      ST_PRIME: begin
        alu_op  = OP_ADD;
        alu_ina = '1;
        alu_inb = DATA_W'(saved_carry[owner_q]);
      end
      ST_EXEC, ST_FLAG: begin
        // FLAG keeps the operands so nothing disturbs the flags being read.
        alu_op  = op_q;
        alu_ina = a_q;
        alu_inb = b_q;
      end
      default: begin
        alu_op  = OP_PASS;
        alu_ina = '0;
        alu_inb = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      owner_q     <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      bigger_q    <= 1'b0;
      saved_carry <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            op_q    <= op_sel;
            owner_q <= req1_ready;
            state   <= uses_carry(op_sel) ? ST_PRIME : ST_EXEC;
          end
        end
        ST_PRIME: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= alu_out;
          state    <= ST_FLAG;
        end
        ST_FLAG: begin
          // ALU flags registered at the end of EXEC are visible now.
          carry_q              <= alu_carry;
          zero_q               <= alu_zero;
          bigger_q             <= alu_bigger;
          saved_carry[owner_q] <= alu_carry;
          state                <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_take) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [15:0] rsp0_out, rsp1_out;
  logic        rsp0_carry, rsp0_zero, rsp0_bigger;
  logic        rsp1_carry, rsp1_zero, rsp1_bigger;
  logic [15:0] alu_ina, alu_inb, alu_out;
  logic [3:0]  alu_op;
  logic        alu_carry, alu_zero, alu_bigger;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(16), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out),
    .rsp0_carry(rsp0_carry), .rsp0_zero(rsp0_zero), .rsp0_bigger(rsp0_bigger),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out),
    .rsp1_carry(rsp1_carry), .rsp1_zero(rsp1_zero), .rsp1_bigger(rsp1_bigger),
    .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_bigger(alu_bigger)
  );

  // ALU stand-in: combinational result, flags registered at posedge.
  // Shifts through carry use the registered carry as carry-in.
  logic [16:0] calc;
  logic        alu_c_r = 1'b0, alu_z_r = 1'b0, alu_b_r = 1'b0;

  always_comb begin
    calc = {1'b0, alu_ina};
    case (alu_op)
      4'b0001: calc = {1'b0, alu_ina} + {1'b0, alu_inb};
      4'b0010: calc = {1'b0, alu_ina} - {1'b0, alu_inb};
      4'b1011: calc = {alu_ina[0], alu_c_r, alu_ina[15:1]};
      4'b1100: calc = {alu_ina[15], alu_ina[14:0], alu_c_r};
      default: calc = {1'b0, alu_ina};
    endcase
  end

  always @(posedge clk) begin
    alu_c_r <= calc[16];
    alu_z_r <= (calc[15:0] == 16'h0000);
    alu_b_r <= (alu_ina > alu_inb);
  end

  assign alu_out    = calc[15:0];
  assign alu_carry  = alu_c_r;
  assign alu_zero   = alu_z_r;
  assign alu_bigger = alu_b_r;

  // Stimulus helpers (no checking inside).
  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present a request and wait (bounded) for its handshake; returns at
  // posedge+1 after the handshake edge with the request withdrawn and its
  // fields scrambled, so late sampling would show up in the result.
  task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, output logic ok);
    ok = 1'b0;
    if (n == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (n == 0) begin
      req0_valid = 1'b0; req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_op = 4'b0111;
    end else begin
      req1_valid = 1'b0; req1_a = 16'hDEAD; req1_b = 16'hBEEF; req1_op = 4'b0111;
    end
  endtask

  // Count negedges until rspN_valid; lat = 0 if it never appears.
  task automatic wait_rsp(input int n, output int lat);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if ((n == 0 && rsp0_valid) || (n == 1 && rsp1_valid)) lat = i;
    end
  endtask

  task automatic test_reset();
    logic ok;
    int   lat;
    rst_n = 1'b0;
    req0_a = 16'h0003; req0_b = 16'h0004; req0_op = 4'b0001; req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (req0_ready !== 1'b0) $display("FAIL reset_ready cyc%0d got %b exp 0", i, req0_ready);
      else pass_cnt++;
    end
    total_cnt++;
    if ({rsp0_valid, rsp1_valid, rsp0_out, rsp0_carry, rsp0_zero, rsp0_bigger, alu_op, alu_ina, alu_inb} !== '0)
      $display("FAIL reset_values got v0=%b v1=%b out=%h op=%h ina=%h inb=%h exp all 0",
               rsp0_valid, rsp1_valid, rsp0_out, alu_op, alu_ina, alu_inb);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 16'h0003, 16'h0004, 4'b0001, ok);
    wait_rsp(0, lat);
    total_cnt++;
    if (lat !== 3) $display("FAIL add_latency got %0d exp 3", lat); else pass_cnt++;
    total_cnt++;
    if ({rsp0_out, rsp0_carry, rsp0_zero, rsp0_bigger} !== {16'h0007, 3'b000})
      $display("FAIL add_result got out=%h c=%b z=%b b=%b exp out=0007 c=0 z=0 b=0",
               rsp0_out, rsp0_carry, rsp0_zero, rsp0_bigger);
    else pass_cnt++;
    total_cnt++;
    if (rsp1_valid !== 1'b0) $display("FAIL nonowner_valid got %b exp 0", rsp1_valid); else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alternate();
    int          g[4];
    int          exp_g[4];
    int          ng;
    int          lat;
    logic        got1;
    logic [15:0] o1;
    logic        c1, z1;
    exp_g = '{0, 1, 0, 1};
    ng = 0;
    got1 = 1'b0;
    o1 = '0; c1 = 1'b0; z1 = 1'b0;
    apply_reset();
    req0_a = 16'h0010; req0_b = 16'h0020; req0_op = 4'b0001; req0_valid = 1'b1;
    req1_a = 16'hFFFF; req1_b = 16'h0001; req1_op = 4'b0001; req1_valid = 1'b1;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (req0_ready) begin g[ng] = 0; ng++; end
      else if (req1_ready) begin g[ng] = 1; ng++; end
      if (rsp1_valid && !got1) begin
        got1 = 1'b1; o1 = rsp1_out; c1 = rsp1_carry; z1 = rsp1_zero;
      end
    end
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(1, lat);
    @(posedge clk);
    #1;
    total_cnt++;
    if (ng !== 4) $display("FAIL grant_count got %0d exp 4", ng); else pass_cnt++;
    for (int i = 0; i < ng; i++) begin
      total_cnt++;
      if (g[i] !== exp_g[i]) $display("FAIL grant_order idx%0d got %0d exp %0d", i, g[i], exp_g[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({got1, o1, c1, z1} !== {1'b1, 16'h0000, 1'b1, 1'b1})
      $display("FAIL req1_wrap got seen=%b out=%h c=%b z=%b exp seen=1 out=0000 c=1 z=1", got1, o1, c1, z1);
    else pass_cnt++;
  endtask

  task automatic test_carry_isolation();
    logic ok;
    int   lat;
    apply_reset();
    issue(0, 16'hFFFF, 16'h0001, 4'b0001, ok);
    wait_rsp(0, lat);
    total_cnt++;
    if (rsp0_carry !== 1'b1) $display("FAIL r0_carry got %b exp 1", rsp0_carry); else pass_cnt++;
    @(posedge clk);
    #1;
    issue(1, 16'h0001, 16'h0001, 4'b0001, ok);
    wait_rsp(1, lat);
    total_cnt++;
    if ({rsp1_out, rsp1_carry} !== {16'h0002, 1'b0})
      $display("FAIL r1_add got out=%h c=%b exp out=0002 c=0", rsp1_out, rsp1_carry);
    else pass_cnt++;
    @(posedge clk);
    #1;
    issue(0, 16'h0002, 16'h0000, 4'b1011, ok);
    @(negedge clk);
    total_cnt++;
    if ({alu_op, alu_ina, alu_inb} !== {4'b0001, 16'hFFFF, 16'h0001})
      $display("FAIL prime_drive got op=%h ina=%h inb=%h exp op=1 ina=ffff inb=0001", alu_op, alu_ina, alu_inb);
    else pass_cnt++;
    wait_rsp(0, lat);
    if (lat != 0) lat = lat + 1;
    total_cnt++;
    if (lat !== 4) $display("FAIL carry_latency got %0d exp 4", lat); else pass_cnt++;
    total_cnt++;
    if ({rsp0_out, rsp0_carry} !== {16'h8001, 1'b0})
      $display("FAIL asrc_cin1 got out=%h c=%b exp out=8001 c=0", rsp0_out, rsp0_carry);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    logic        ok;
    int          lat;
    logic [15:0] held;
    apply_reset();
    rsp0_ready = 1'b0;
    issue(0, 16'h1234, 16'h0001, 4'b0001, ok);
    req1_a = 16'h0100; req1_b = 16'h0001; req1_op = 4'b0001; req1_valid = 1'b1;
    wait_rsp(0, lat);
    held = rsp0_out;
    total_cnt++;
    if (held !== 16'h1235) $display("FAIL stall_data got %h exp 1235", held); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      total_cnt++;
      if ({rsp0_valid, rsp0_out, req1_ready} !== {1'b1, held, 1'b0})
        $display("FAIL stall_hold cyc%0d got v=%b out=%h r1rdy=%b exp v=1 out=%h r1rdy=0",
                 i, rsp0_valid, rsp0_out, req1_ready, held);
      else pass_cnt++;
    end
    rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({req1_ready, rsp0_valid} !== 2'b10)
      $display("FAIL release_grant got r1rdy=%b v0=%b exp r1rdy=1 v0=0", req1_ready, rsp0_valid);
    else pass_cnt++;
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_rsp(1, lat);
    total_cnt++;
    if (rsp1_out !== 16'h0101) $display("FAIL after_stall got %h exp 0101", rsp1_out); else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_exec();
    logic ok;
    int   lat;
    logic seen;
    apply_reset();
    issue(0, 16'hFFFF, 16'h0001, 4'b0001, ok);
    wait_rsp(0, lat);
    @(posedge clk);
    #1;
    issue(0, 16'hFFFF, 16'h0001, 4'b0001, ok);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rsp0_valid, rsp1_valid, rsp0_out, rsp0_carry, rsp0_zero, rsp0_bigger, alu_op, alu_ina, alu_inb, req0_ready} !== '0)
      $display("FAIL abort_values got v0=%b out=%h c=%b z=%b b=%b op=%h ina=%h exp all 0",
               rsp0_valid, rsp0_out, rsp0_carry, rsp0_zero, rsp0_bigger, alu_op, alu_ina);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_no_rsp got %b exp 0", seen); else pass_cnt++;
    @(posedge clk);
    #1;
    issue(0, 16'h0002, 16'h0000, 4'b1011, ok);
    @(negedge clk);
    total_cnt++;
    if (alu_inb !== 16'h0000) $display("FAIL prime_cleared got inb=%h exp 0000", alu_inb); else pass_cnt++;
    wait_rsp(0, lat);
    total_cnt++;
    if (rsp0_out !== 16'h0001) $display("FAIL asrc_cin0 got %h exp 0001", rsp0_out); else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub();
    logic ok;
    int   lat;
    apply_reset();
    issue(0, 16'h0005, 16'h0003, 4'b0010, ok);
    wait_rsp(0, lat);
    total_cnt++;
    if ({lat == 3, rsp0_out, rsp0_bigger, rsp0_carry} !== {1'b1, 16'h0002, 1'b1, 1'b0})
      $display("FAIL sub_result got lat=%0d out=%h b=%b c=%b exp lat=3 out=0002 b=1 c=0",
               lat, rsp0_out, rsp0_bigger, rsp0_carry);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_carry_isolation();
    test_stall();
    test_reset_mid_exec();
    test_sub();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
